// File: rtl/hyperbus_pkg.sv
// Shared types and constants for the Wishbone to HyperBus bridge.
package hyperbus_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_REQ,
        ST_WDATA,
        ST_RDATA,
        ST_ACK,
        ST_ERR
    } state_t;

    localparam logic [2:0] CTI_CLASSIC = 3'b000;
    localparam logic [2:0] CTI_INCR    = 3'b010;
    localparam logic [2:0] CTI_EOB     = 3'b111;

    localparam logic [1:0] BTE_LINEAR = 2'b00;
    localparam logic [1:0] BTE_WRAP4  = 2'b01;
    localparam logic [1:0] BTE_WRAP8  = 2'b10;
    localparam logic [1:0] BTE_WRAP16 = 2'b11;

    // Beat-index bits that may change inside a wrapping burst (beats - 1).
    function automatic logic [3:0] wrap_mask(input logic [1:0] bte);
        case (bte)
            BTE_WRAP4:  return 4'd3;
            BTE_WRAP8:  return 4'd7;
            BTE_WRAP16: return 4'd15;
            default:    return 4'd0;
        endcase
    endfunction

endpackage

// File: rtl/hyperbus_width_conv.sv
// R-slice serializer/deserializer: one wide register walked a narrow slice
// at a time, least-significant slice first.
module hyperbus_width_conv #(
    parameter int WIDE_WIDTH   = 32,
    parameter int NARROW_WIDTH = 16
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      load,
    input  logic                      step,
    input  logic                      store,
    input  logic [WIDE_WIDTH-1:0]     wide_i,
    input  logic [WIDE_WIDTH/8-1:0]   sel_i,
    input  logic [NARROW_WIDTH-1:0]   narrow_i,
    output logic [WIDE_WIDTH-1:0]     wide_o,
    output logic [NARROW_WIDTH-1:0]   narrow_o,
    output logic [NARROW_WIDTH/8-1:0] mask_o,
    output logic                      last
);
    localparam int R  = WIDE_WIDTH / NARROW_WIDTH;
    localparam int MW = NARROW_WIDTH / 8;
    localparam int KW = (R > 1) ? $clog2(R) : 1;

    logic [WIDE_WIDTH-1:0]   data_q;
    logic [WIDE_WIDTH/8-1:0] sel_q;
    logic [KW-1:0]           k;

    // Load resets the slice pointer; step (serialize) and store (deserialize)
    // both advance it, wrapping after the last slice so back-to-back beats
    // start at slice 0 again.
    always_ff @(posedge clk) begin
        if (rst) begin
            data_q <= '0;
            sel_q  <= '0;
            k      <= '0;
        end else if (load) begin
            data_q <= wide_i;
            sel_q  <= sel_i;
            k      <= '0;
        end else if (step || store) begin
            if (store)
                data_q[int'(k)*NARROW_WIDTH +: NARROW_WIDTH] <= narrow_i;
            k <= last ? '0 : k + 1'b1;
        end
    end

    assign last     = (k == KW'(R - 1));
    assign wide_o   = data_q;
    assign narrow_o = data_q[int'(k)*NARROW_WIDTH +: NARROW_WIDTH];
    assign mask_o   = sel_q[int'(k)*MW +: MW];

endmodule

// File: rtl/hyperbus_wb_bridge.sv
// Wishbone B4 classic slave turning each access into one HyperBus controller
// transaction of R words, with incrementing bursts and a stall watchdog.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | waiting for cyc&stb
// ST_REQ   | rrq/wrq held until the controller raises busy
// ST_WDATA | serializing write words with wvalid/wready
// ST_RDATA | collecting read words qualified by rvalid
// ST_ACK   | wb_ack_o high; continue an incrementing burst or go idle
// ST_ERR   | wb_err_o high after a watchdog expiry
module hyperbus_wb_bridge
    import hyperbus_pkg::*;
#(
    parameter int WB_DATA_WIDTH   = 32,
    parameter int WB_ADDR_WIDTH   = 32,
    parameter int HBUS_DATA_WIDTH = 16,
    parameter int TIMEOUT_CYCLES  = 1024
) (
    input  logic                         wb_clk,
    input  logic                         wb_rst,
    input  logic [WB_ADDR_WIDTH-1:0]     wb_adr_i,
    input  logic [WB_DATA_WIDTH-1:0]     wb_dat_i,
    input  logic [WB_DATA_WIDTH/8-1:0]   wb_sel_i,
    input  logic                         wb_we_i,
    input  logic                         wb_cyc_i,
    input  logic                         wb_stb_i,
    input  logic [2:0]                   wb_cti_i,
    input  logic [1:0]                   wb_bte_i,
    output logic [WB_DATA_WIDTH-1:0]     wb_dat_o,
    output logic                         wb_ack_o,
    output logic                         wb_err_o,
    output logic                         wb_rty_o,
    output logic [WB_ADDR_WIDTH-1:0]     hbus_adr_o,
    output logic [7:0]                   hbus_len_o,
    output logic                         hbus_rrq,
    output logic                         hbus_wrq,
    input  logic                         hbus_busy,
    output logic [HBUS_DATA_WIDTH-1:0]   hbus_dat_o,
    output logic [HBUS_DATA_WIDTH/8-1:0] hbus_mask_o,
    output logic                         hbus_wvalid,
    input  logic                         hbus_wready,
    input  logic [HBUS_DATA_WIDTH-1:0]   hbus_dat_i,
    input  logic                         hbus_rvalid
);
    localparam int R          = WB_DATA_WIDTH / HBUS_DATA_WIDTH;
    localparam int MW         = HBUS_DATA_WIDTH / 8;
    localparam int WB_BYTES   = WB_DATA_WIDTH / 8;
    localparam int ADR_SHIFT  = $clog2(MW);
    localparam int BEAT_SHIFT = $clog2(WB_BYTES);
    localparam int WD_W       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [WD_W-1:0] WD_LOAD = WD_W'(TIMEOUT_CYCLES - 1);

    state_t                   state;
    logic [WB_ADDR_WIDTH-1:0] adr_q;
    logic                     we_q;
    logic                     aborted;
    logic [WD_W-1:0]          wd_cnt;

    logic                     start, load, wr_xfer, rd_xfer, conv_last;
    logic                     wd_reload, wd_expired;
    logic [WB_ADDR_WIDTH-1:0] adr_inc, wrap_bits, next_adr;

    assign wb_rty_o   = 1'b0;
    assign hbus_len_o = 8'(R);
    assign hbus_adr_o = adr_q >> ADR_SHIFT;

    // Write data is captured at the start and re-sampled while a write
    // request is pending, so the next burst beat's data (presented after the
    // previous ack) is what gets serialized.
    assign start   = (state == ST_IDLE) && wb_cyc_i && wb_stb_i;
    assign load    = start || ((state == ST_REQ) && we_q && wb_cyc_i && wb_stb_i);
    assign wr_xfer = (state == ST_WDATA) && hbus_wvalid && hbus_wready;
    assign rd_xfer = (state == ST_RDATA) && hbus_rvalid;

    assign wd_reload  = (state == ST_IDLE) || (state == ST_ACK) || (state == ST_ERR) ||
                        ((state == ST_REQ) && hbus_busy) || wr_xfer || rd_xfer;
    assign wd_expired = (wd_cnt == '0);

    // Next burst address: linear increment, or only the beat-index bits
    // inside the wrap window take the incremented value.
    always_comb begin
        adr_inc   = adr_q + WB_ADDR_WIDTH'(WB_BYTES);
        wrap_bits = WB_ADDR_WIDTH'(wrap_mask(wb_bte_i)) << BEAT_SHIFT;
        if (wb_bte_i == BTE_LINEAR)
            next_adr = adr_inc;
        else
            next_adr = (adr_q & ~wrap_bits) | (adr_inc & wrap_bits);
    end

    hyperbus_width_conv #(
        .WIDE_WIDTH  (WB_DATA_WIDTH),
        .NARROW_WIDTH(HBUS_DATA_WIDTH)
    ) u_conv (
        .clk     (wb_clk),
        .rst     (wb_rst),
        .load    (load),
        .step    (wr_xfer),
        .store   (rd_xfer),
        .wide_i  (wb_dat_i),
        .sel_i   (wb_sel_i),
        .narrow_i(hbus_dat_i),
        .wide_o  (wb_dat_o),
        .narrow_o(hbus_dat_o),
        .mask_o  (hbus_mask_o),
        .last    (conv_last)
    );

    // Bridge sequencer with registered request/handshake/termination outputs
    // and the watchdog down-counter.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state       <= ST_IDLE;
            adr_q       <= '0;
            we_q        <= 1'b0;
            aborted     <= 1'b0;
            wd_cnt      <= WD_LOAD;
            hbus_rrq    <= 1'b0;
            hbus_wrq    <= 1'b0;
            hbus_wvalid <= 1'b0;
            wb_ack_o    <= 1'b0;
            wb_err_o    <= 1'b0;
        end else begin
            wb_ack_o <= 1'b0;
            wb_err_o <= 1'b0;
            if (wd_reload)
                wd_cnt <= WD_LOAD;
            else if (!wd_expired)
                wd_cnt <= wd_cnt - 1'b1;

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        adr_q    <= wb_adr_i;
                        we_q     <= wb_we_i;
                        aborted  <= 1'b0;
                        hbus_wrq <= wb_we_i;
                        hbus_rrq <= !wb_we_i;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (hbus_busy) begin
                        hbus_rrq    <= 1'b0;
                        hbus_wrq    <= 1'b0;
                        hbus_wvalid <= we_q;
                        aborted     <= !wb_cyc_i;
                        state       <= we_q ? ST_WDATA : ST_RDATA;
                    end else if (!wb_cyc_i) begin
                        hbus_rrq <= 1'b0;
                        hbus_wrq <= 1'b0;
                        state    <= ST_IDLE;
                    end else if (wd_expired) begin
                        hbus_rrq <= 1'b0;
                        hbus_wrq <= 1'b0;
                        wb_err_o <= 1'b1;
                        state    <= ST_ERR;
                    end
                end
                ST_WDATA, ST_RDATA: begin
                    if (!wb_cyc_i)
                        aborted <= 1'b1;
                    if ((wr_xfer || rd_xfer) && conv_last) begin
                        hbus_wvalid <= 1'b0;
                        // An abandoned cycle finishes the controller
                        // transaction silently.
                        if (aborted || !wb_cyc_i) begin
                            state <= ST_IDLE;
                        end else begin
                            wb_ack_o <= 1'b1;
                            state    <= ST_ACK;
                        end
                    end else if (!(wr_xfer || rd_xfer) && wd_expired) begin
                        hbus_wvalid <= 1'b0;
                        if (aborted || !wb_cyc_i) begin
                            state <= ST_IDLE;
                        end else begin
                            wb_err_o <= 1'b1;
                            state    <= ST_ERR;
                        end
                    end
                end
                ST_ACK: begin
                    if (wb_cyc_i && wb_stb_i && (wb_cti_i == CTI_INCR)) begin
                        adr_q    <= next_adr;
                        hbus_wrq <= we_q;
                        hbus_rrq <= !we_q;
                        state    <= ST_REQ;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_ERR: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hyperbus_wb_bridge.sv
// Directed and randomized bench for hyperbus_wb_bridge (32-bit Wishbone,
// 16-bit controller, 16-cycle watchdog).
module tb_hyperbus_wb_bridge;
    import hyperbus_pkg::*;

    localparam int WBW = 32;
    localparam int HBW = 16;
    localparam int AW  = 32;
    localparam int TMO = 16;
    localparam int R   = WBW / HBW;

    logic           clk = 1'b0;
    logic           rst;
    logic [AW-1:0]  adr_i;
    logic [WBW-1:0] dat_i;
    logic [3:0]     sel_i;
    logic           we_i, cyc_i, stb_i;
    logic [2:0]     cti_i;
    logic [1:0]     bte_i;
    logic [WBW-1:0] wb_dat_o;
    logic           wb_ack_o, wb_err_o, wb_rty_o;
    logic [AW-1:0]  hbus_adr_o;
    logic [7:0]     hbus_len_o;
    logic           hbus_rrq, hbus_wrq, hbus_busy;
    logic [HBW-1:0] hbus_dat_o;
    logic [1:0]     hbus_mask_o;
    logic           hbus_wvalid, hbus_wready;
    logic [HBW-1:0] hbus_dat_i;
    logic           hbus_rvalid;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    hyperbus_wb_bridge #(
        .WB_DATA_WIDTH  (WBW),
        .WB_ADDR_WIDTH  (AW),
        .HBUS_DATA_WIDTH(HBW),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .wb_clk     (clk),
        .wb_rst     (rst),
        .wb_adr_i   (adr_i),
        .wb_dat_i   (dat_i),
        .wb_sel_i   (sel_i),
        .wb_we_i    (we_i),
        .wb_cyc_i   (cyc_i),
        .wb_stb_i   (stb_i),
        .wb_cti_i   (cti_i),
        .wb_bte_i   (bte_i),
        .wb_dat_o   (wb_dat_o),
        .wb_ack_o   (wb_ack_o),
        .wb_err_o   (wb_err_o),
        .wb_rty_o   (wb_rty_o),
        .hbus_adr_o (hbus_adr_o),
        .hbus_len_o (hbus_len_o),
        .hbus_rrq   (hbus_rrq),
        .hbus_wrq   (hbus_wrq),
        .hbus_busy  (hbus_busy),
        .hbus_dat_o (hbus_dat_o),
        .hbus_mask_o(hbus_mask_o),
        .hbus_wvalid(hbus_wvalid),
        .hbus_wready(hbus_wready),
        .hbus_dat_i (hbus_dat_i),
        .hbus_rvalid(hbus_rvalid)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference burst address: step one 4-byte beat, wrapping inside an
    // aligned window of 4/8/16 beats.
    function automatic logic [31:0] model_next(input logic [31:0] a, input logic [1:0] b);
        int unsigned span;
        if (b == 2'b00) return a + 32'd4;
        span = 4 * (4 << (int'(b) - 1));
        return (a / span) * span + ((a % span) + 4) % span;
    endfunction

    task automatic idle_bus();
        cyc_i = 1'b0;
        stb_i = 1'b0;
        we_i  = 1'b0;
        cti_i = CTI_CLASSIC;
        bte_i = BTE_LINEAR;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ack"},  64'(wb_ack_o), 64'(0));
        chk({tag, "_err"},  64'(wb_err_o), 64'(0));
        chk({tag, "_rty"},  64'(wb_rty_o), 64'(0));
        chk({tag, "_rrq"},  64'(hbus_rrq), 64'(0));
        chk({tag, "_wrq"},  64'(hbus_wrq), 64'(0));
        chk({tag, "_wvld"}, 64'(hbus_wvalid), 64'(0));
        chk({tag, "_rdat"}, 64'(wb_dat_o), 64'(0));
        chk({tag, "_hdat"}, 64'(hbus_dat_o), 64'(0));
        chk({tag, "_hadr"}, 64'(hbus_adr_o), 64'(0));
        chk({tag, "_mask"}, 64'(hbus_mask_o), 64'(0));
        chk({tag, "_len"},  64'(hbus_len_o), 64'(R));
    endtask

    // One Wishbone beat, entered at a negedge with the beat presented;
    // returns at the negedge just after the ack cycle.
    task automatic run_beat(input string tag, input logic is_wr, input logic [31:0] adr,
                            input logic [31:0] wdat, input logic [3:0] sel,
                            input logic [31:0] rdat, input int req_lat);
        int n;
        int gap;
        int stall;
        n = 0;
        while (!(is_wr ? hbus_wrq : hbus_rrq) && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_req_lat"}, 64'(n), 64'(req_lat));
        chk({tag, "_other_req"}, 64'(is_wr ? hbus_rrq : hbus_wrq), 64'(0));
        chk({tag, "_hadr"}, 64'(hbus_adr_o), 64'(adr >> 1));
        chk({tag, "_len"}, 64'(hbus_len_o), 64'(R));
        gap = $urandom_range(0, 3);
        for (int g = 0; g < gap; g++) begin
            hbus_busy = 1'b0;
            @(negedge clk);
            chk({tag, "_req_hold"}, 64'(is_wr ? hbus_wrq : hbus_rrq), 64'(1));
        end
        hbus_busy = 1'b1;
        @(negedge clk);
        hbus_busy = 1'b0;
        chk({tag, "_req_drop"}, 64'(hbus_wrq | hbus_rrq), 64'(0));
        for (int k = 0; k < R; k++) begin
            stall = $urandom_range(0, 2);
            for (int s = 0; s <= stall; s++) begin
                if (is_wr) begin
                    chk({tag, "_wvalid"}, 64'(hbus_wvalid), 64'(1));
                    chk({tag, "_wword"}, 64'(hbus_dat_o), 64'(16'(wdat >> (HBW * k))));
                    chk({tag, "_wmask"}, 64'(hbus_mask_o), 64'(2'(sel >> (2 * k))));
                    hbus_wready = (s == stall);
                end else begin
                    hbus_rvalid = (s == stall);
                    hbus_dat_i  = (s == stall) ? 16'(rdat >> (HBW * k)) : 16'($urandom);
                end
                chk({tag, "_early_ack"}, 64'(wb_ack_o), 64'(0));
                @(negedge clk);
            end
            hbus_wready = 1'b0;
            hbus_rvalid = 1'b0;
        end
        chk({tag, "_ack"}, 64'(wb_ack_o), 64'(1));
        chk({tag, "_err"}, 64'(wb_err_o), 64'(0));
        chk({tag, "_wvalid_off"}, 64'(hbus_wvalid), 64'(0));
        if (!is_wr)
            chk({tag, "_rdata"}, 64'(wb_dat_o), 64'(rdat));
        @(negedge clk);
        chk({tag, "_ack_pulse"}, 64'(wb_ack_o), 64'(0));
    endtask

    task automatic single(input string tag, input logic wr, input logic [31:0] adr,
                          input logic [31:0] wdat, input logic [3:0] sel, input logic [31:0] rdat);
        @(negedge clk);
        adr_i = adr;
        dat_i = wdat;
        sel_i = sel;
        we_i  = wr;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        cti_i = CTI_CLASSIC;
        bte_i = BTE_LINEAR;
        run_beat(tag, wr, adr, wdat, sel, rdat, 1);
        idle_bus();
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout observed no finish expected finish");
        $fatal(1);
    end

    initial begin
        int n;
        logic        wr;
        int          beats;
        logic [1:0]  b;
        logic [31:0] a, wd, rd;
        logic [3:0]  sl;

        rst = 1'b1;
        adr_i = '0;
        dat_i = '0;
        sel_i = '0;
        idle_bus();
        hbus_busy   = 1'b0;
        hbus_wready = 1'b0;
        hbus_dat_i  = '0;
        hbus_rvalid = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst = 1'b0;

        single("wr100", 1'b1, 32'h100, 32'h1234_5678, 4'hF, 32'h0);
        single("rd104", 1'b0, 32'h104, 32'h0, 4'h0, 32'hDEAD_BEEF);
        single("wrsel", 1'b1, 32'h208, 32'hA5A5_5A5A, 4'b0100, 32'h0);

        // Wrap-4 write burst from 0x18.
        a = 32'h18;
        @(negedge clk);
        cyc_i = 1'b1;
        stb_i = 1'b1;
        we_i  = 1'b1;
        bte_i = BTE_WRAP4;
        for (int bt = 0; bt < 4; bt++) begin
            wd = $urandom;
            adr_i = a;
            dat_i = wd;
            sel_i = 4'hF;
            cti_i = (bt == 3) ? CTI_EOB : CTI_INCR;
            run_beat("burst_w4", 1'b1, a, wd, 4'hF, 32'h0, (bt == 0) ? 1 : 0);
            a = model_next(a, BTE_WRAP4);
        end
        idle_bus();

        // Watchdog: controller never accepts.
        @(negedge clk);
        adr_i = 32'h40;
        dat_i = 32'h0BAD_F00D;
        sel_i = 4'hF;
        we_i  = 1'b1;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        hbus_busy = 1'b0;
        n = 0;
        while (!hbus_wrq && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("tmo_req_lat", 64'(n), 64'(1));
        n = 0;
        while (hbus_wrq && n < 40) begin
            chk("tmo_no_ack", 64'(wb_ack_o), 64'(0));
            chk("tmo_no_early_err", 64'(wb_err_o), 64'(0));
            @(negedge clk);
            n++;
        end
        chk("tmo_req_cycles", 64'(n), 64'(TMO));
        chk("tmo_err", 64'(wb_err_o), 64'(1));
        chk("tmo_ack", 64'(wb_ack_o), 64'(0));
        @(negedge clk);
        chk("tmo_err_pulse", 64'(wb_err_o), 64'(0));
        idle_bus();

        // Cycle dropped during WDATA: words complete from latched data, no ack.
        @(negedge clk);
        adr_i = 32'h300;
        dat_i = 32'hCAFE_F00D;
        sel_i = 4'hF;
        we_i  = 1'b1;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        n = 0;
        while (!hbus_wrq && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("abort_req_lat", 64'(n), 64'(1));
        hbus_busy = 1'b1;
        @(negedge clk);
        hbus_busy = 1'b0;
        idle_bus();
        dat_i = 32'h3501_0FF2;
        for (int k = 0; k < R; k++) begin
            hbus_wready = 1'b1;
            chk("abort_wvalid", 64'(hbus_wvalid), 64'(1));
            chk("abort_word", 64'(hbus_dat_o), 64'(16'(32'hCAFE_F00D >> (HBW * k))));
            @(negedge clk);
        end
        hbus_wready = 1'b0;
        chk("abort_no_ack", 64'(wb_ack_o), 64'(0));
        chk("abort_wvalid_off", 64'(hbus_wvalid), 64'(0));
        @(negedge clk);
        chk("abort_no_ack2", 64'(wb_ack_o), 64'(0));

        // Cycle dropped while the request is still pending.
        @(negedge clk);
        adr_i = 32'h500;
        we_i  = 1'b0;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        @(negedge clk);
        chk("reqdrop_rrq", 64'(hbus_rrq), 64'(1));
        idle_bus();
        @(negedge clk);
        chk("reqdrop_rrq_off", 64'(hbus_rrq), 64'(0));
        @(negedge clk);
        chk("reqdrop_no_ack", 64'(wb_ack_o), 64'(0));

        // Reset in the middle of a read.
        @(negedge clk);
        adr_i = 32'h200;
        we_i  = 1'b0;
        cyc_i = 1'b1;
        stb_i = 1'b1;
        n = 0;
        while (!hbus_rrq && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("rst_req_lat", 64'(n), 64'(1));
        hbus_busy = 1'b1;
        @(negedge clk);
        hbus_busy   = 1'b0;
        hbus_rvalid = 1'b1;
        hbus_dat_i  = 16'h1111;
        @(negedge clk);
        hbus_rvalid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        check_reset_outputs("rst_mid");
        rst = 1'b0;
        idle_bus();
        repeat (2) begin
            @(negedge clk);
            chk("rst_no_ack", 64'(wb_ack_o), 64'(0));
            chk("rst_no_err", 64'(wb_err_o), 64'(0));
        end
        single("rd_after_rst", 1'b0, 32'h204, 32'h0, 4'h0, 32'h600D_CAFE);

        // Randomized single accesses and bursts of either direction.
        for (int t = 0; t < 10; t++) begin
            wr    = 1'($urandom_range(0, 1));
            beats = $urandom_range(1, 4);
            b     = 2'($urandom_range(0, 3));
            a     = $urandom_range(0, 32'hFFFF) & ~32'h3;
            @(negedge clk);
            cyc_i = 1'b1;
            stb_i = 1'b1;
            we_i  = wr;
            bte_i = b;
            for (int bt = 0; bt < beats; bt++) begin
                wd = $urandom;
                rd = $urandom;
                sl = 4'($urandom_range(0, 15));
                adr_i = a;
                dat_i = wd;
                sel_i = sl;
                if (bt == beats - 1)
                    cti_i = (beats == 1) ? CTI_CLASSIC : CTI_EOB;
                else
                    cti_i = CTI_INCR;
                run_beat(wr ? "rnd_wr" : "rnd_rd", wr, a, wd, sl, rd, (bt == 0) ? 1 : 0);
                a = model_next(a, b);
            end
            idle_bus();
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
